ifu_fetch: RTL

- Instruction fetch stage plus IF/ID pipeline register for the 5-stage MIPS-C3 core.
- Holds the PC, drives the instruction-memory word address, and registers the fetched instruction and PC+4 into D.
- D-stage outputs, including the 16-bit immediate field, feed the immediate extender and the decoder.
- Resolves next-PC from sequential, branch, j/jal and jr requests with MIPS delay-slot semantics (no squash of the slot).

---
 rtl/ifu_fetch.sv | 97 +++++++++
 1 files changed

// File: rtl/ifu_fetch.sv
// Instruction fetch stage and IF/ID pipeline register for the MIPS-C3 core.
// Next-PC resolution follows MIPS delay-slot semantics: the slot is never squashed.
module ifu_fetch #(
    parameter logic [31:0] PC_RESET  = 32'h0000_3000,
    parameter logic [31:0] IMEM_BASE = 32'h0000_3000,
    parameter int          IMEM_AW   = 12
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               br_taken,
    input  logic [31:0]        br_imm32,
    input  logic               j_taken,
    input  logic [25:0]        j_index,
    input  logic               jr_taken,
    input  logic [31:0]        jr_target,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        pc_f,
    output logic [31:0]        instr_d,
    output logic [31:0]        pc_d,
    output logic [31:0]        pc4_d,
    output logic [15:0]        imm16_d,
    output logic               adel_d
);

    // One past the last valid byte address; 33 bits so the bound cannot overflow.
    localparam logic [32:0] IMEM_LIMIT = {1'b0, IMEM_BASE} + (33'd1 << (IMEM_AW + 2));

    logic [31:0] pc_r;
    logic [31:0] instr_r;
    logic [31:0] pc_d_r;
    logic [31:0] pc4_r;
    logic        adel_r;

    logic [31:0] pc_plus4_s;
    logic [31:0] offset_s;
    logic        adel_f_s;
    logic [31:0] fetch_word_s;
    logic [31:0] npc_s;

    assign pc_plus4_s = pc_r + 32'd4;
    assign offset_s   = pc_r - IMEM_BASE;
    assign imem_addr  = offset_s[IMEM_AW+1:2];

    // Fetch address error detection and masking of the fetched word.
    always_comb begin
        adel_f_s     = 1'b0;
        fetch_word_s = imem_rdata;
        if ((pc_r[1:0] != 2'b00) || (pc_r < IMEM_BASE) || ({1'b0, pc_r} >= IMEM_LIMIT)) begin
            adel_f_s     = 1'b1;
            fetch_word_s = 32'h0000_0000;
        end else begin
            adel_f_s     = 1'b0;
            fetch_word_s = imem_rdata;
        end
    end

    // Next-PC priority mux; stall is handled at the register, not here.
    always_comb begin
        npc_s = pc_plus4_s;
        if (jr_taken) begin
            npc_s = jr_target;
        end else if (j_taken) begin
            npc_s = {pc4_r[31:28], j_index, 2'b00};
        end else if (br_taken) begin
            npc_s = pc4_r + {br_imm32[29:0], 2'b00};
        end else begin
            npc_s = pc_plus4_s;
        end
    end

    // PC and IF/ID state; reset overrides stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r    <= PC_RESET;
            instr_r <= 32'h0000_0000;
            pc_d_r  <= 32'h0000_0000;
            pc4_r   <= 32'h0000_0000;
            adel_r  <= 1'b0;
        end else if (!stall) begin
            pc_r    <= npc_s;
            instr_r <= fetch_word_s;
            pc_d_r  <= pc_r;
            pc4_r   <= pc_plus4_s;
            adel_r  <= adel_f_s;
        end
    end

    assign pc_f    = pc_r;
    assign instr_d = instr_r;
    assign pc_d    = pc_d_r;
    assign pc4_d   = pc4_r;
    assign imm16_d = instr_r[15:0];
    assign adel_d  = adel_r;

endmodule
